// File: rtl/lsu_ctrl_if.sv
// Word-wide req/ack data-memory port between the load/store unit and memory.
// The master issues requests; the slave answers with ack and read data.
interface lsu_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit: issues one or two word transactions per access, stalls the
// datapath meanwhile and returns sign/zero-extended load data with a done pulse.
module lsu_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mem_wren,
  input  logic [2:0]        l_length,
  input  logic              l_unsigned,
  input  logic [1:0]        s_length,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       st_data,
  output logic [31:0]       ld_data,
  output logic              done,
  output logic              err,
  output logic              stall,
  lsu_ctrl_if.master        mem
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t      state_r, state_nx;
  logic        wren_r, uns_r, split_r, err_r;
  logic [1:0]  sz_r, off_r;
  logic [3:0]  mask_r;
  logic [31:0] st_r, lo_r, ld_r;

  logic [1:0]  sz_in;
  logic        ill_in, uns_in, split_in, ack_v;
  logic [3:0]  mask_in, be_lo_in, be_hi;
  logic [31:0] wd_lo_in, wd_hi, asm_hi, asm_lo, ld_win;

  // Size code 0/1/2 selects a 1/2/4-byte access; extension from bit 8n-1.
  function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [1:0] sz,
                                         input logic uns);
    case (sz)
      2'd0:    ld_ext = uns ? {24'd0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
      2'd1:    ld_ext = uns ? {16'd0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      default: ld_ext = w;
    endcase
  endfunction

  always_comb begin
    sz_in  = 2'd0;
    ill_in = 1'b0;
    if (mem_wren) begin
      sz_in  = s_length;
      ill_in = (s_length == 2'b11);
    end else begin
      sz_in  = l_length[1:0];
      ill_in = (l_length[1:0] == 2'b11) || (l_length == 3'b110);
    end
    uns_in = l_unsigned | l_length[2];
    case (sz_in)
      2'd0:    mask_in = 4'b0001;
      2'd1:    mask_in = 4'b0011;
      default: mask_in = 4'b1111;
    endcase
  end

  // Lanes of the low word come from the live inputs, the high word from captured state.
  assign be_lo_in = mask_in << addr[1:0];
  assign wd_lo_in = st_data << {addr[1:0], 3'b000};
  assign split_in = |(mask_in >> (3'd4 - {1'b0, addr[1:0]}));
  assign be_hi    = mask_r >> (3'd4 - {1'b0, off_r});
  assign wd_hi    = st_r >> {(3'd4 - {1'b0, off_r}), 3'b000};

  assign ack_v  = mem.mem_ack & mem.mem_req;
  assign asm_hi = (state_r == ACC1) ? mem.mem_rdata : 32'd0;
  assign asm_lo = (state_r == ACC1) ? lo_r : mem.mem_rdata;
  assign ld_win = 32'({asm_hi, asm_lo} >> {off_r, 3'b000});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nx;
  end

  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: if (start) state_nx = ill_in ? RESP : ACC0;
      ACC0: if (ack_v) state_nx = split_r ? ACC1 : RESP;
      ACC1: if (ack_v) state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    done  = (state_r == RESP);
    err   = (state_r == RESP) & err_r;
    stall = ((state_r == IDLE) & start) | (state_r == ACC0) | (state_r == ACC1);
  end

  assign ld_data = ld_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wren_r        <= 1'b0;
      uns_r         <= 1'b0;
      split_r       <= 1'b0;
      err_r         <= 1'b0;
      sz_r          <= 2'd0;
      off_r         <= 2'd0;
      mask_r        <= 4'd0;
      st_r          <= 32'd0;
      lo_r          <= 32'd0;
      ld_r          <= 32'd0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_be    <= 4'd0;
      mem.mem_wdata <= 32'd0;
    end else begin
      case (state_r)
        IDLE: if (start) begin
          wren_r  <= mem_wren;
          uns_r   <= uns_in;
          split_r <= split_in;
          err_r   <= ill_in;
          sz_r    <= sz_in;
          off_r   <= addr[1:0];
          mask_r  <= mask_in;
          st_r    <= st_data;
          ld_r    <= 32'd0;
          if (!ill_in) begin
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= mem_wren;
            mem.mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
            mem.mem_be    <= be_lo_in;
            mem.mem_wdata <= wd_lo_in;
          end
        end
        ACC0: if (ack_v) begin
          lo_r <= mem.mem_rdata;
          if (split_r) begin
            mem.mem_addr  <= mem.mem_addr + ADDR_W'(4);
            mem.mem_be    <= be_hi;
            mem.mem_wdata <= wd_hi;
          end else begin
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            if (!wren_r) ld_r <= ld_ext(ld_win, sz_r, uns_r);
          end
        end
        ACC1: if (ack_v) begin
          mem.mem_req <= 1'b0;
          mem.mem_we  <= 1'b0;
          if (!wren_r) ld_r <= ld_ext(ld_win, sz_r, uns_r);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: table of directed accesses with a zero-wait memory, plus
// sequences for wait states, back-to-back starts and reset during an access.
module tb_lsu_ctrl;
  logic        clk = 1'b0;
  logic        rst, start, mem_wren, l_unsigned;
  logic [2:0]  l_length;
  logic [1:0]  s_length;
  logic [31:0] addr, st_data, ld_data;
  logic        done, err, stall;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  lsu_ctrl_if #(.ADDR_W(32)) mif ();

  lsu_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_wren(mem_wren),
    .l_length(l_length), .l_unsigned(l_unsigned), .s_length(s_length),
    .addr(addr), .st_data(st_data), .ld_data(ld_data), .done(done),
    .err(err), .stall(stall), .mem(mif)
  );

  typedef struct {
    logic        we;
    logic [2:0]  llen;
    logic        luns;
    logic [1:0]  slen;
    logic [31:0] a, st, rlo, rhi;
    int          nacc;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] wd0, a1;
    logic [3:0]  be1;
    logic [31:0] wd1, ld;
    logic        er;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int cyc;
    int ph;
    mem_wren = v.we; l_length = v.llen; l_unsigned = v.luns; s_length = v.slen;
    addr = v.a; st_data = v.st; mif.mem_ack = 1'b0; start = 1'b1;
    #1;
    chk($sformatf("v%0d_stall_start", i), stall, 1'b1);
    step();
    start = 1'b0;
    cyc = 1;
    ph = 0;
    while (!done && cyc < 6) begin
      chk($sformatf("v%0d_req%0d", i, ph), mif.mem_req, 1'b1);
      chk($sformatf("v%0d_we%0d", i, ph), mif.mem_we, v.we);
      chk($sformatf("v%0d_addr%0d", i, ph), mif.mem_addr, (ph == 0) ? v.a0 : v.a1);
      chk($sformatf("v%0d_be%0d", i, ph), mif.mem_be, (ph == 0) ? v.be0 : v.be1);
      chk($sformatf("v%0d_wdata%0d", i, ph), mif.mem_wdata, (ph == 0) ? v.wd0 : v.wd1);
      chk($sformatf("v%0d_stall%0d", i, ph), stall, 1'b1);
      mif.mem_ack = 1'b1;
      mif.mem_rdata = (ph == 0) ? v.rlo : v.rhi;
      step();
      mif.mem_ack = 1'b0;
      cyc++;
      ph++;
    end
    chk($sformatf("v%0d_latency", i), cyc, v.nacc + 1);
    chk($sformatf("v%0d_done", i), done, 1'b1);
    chk($sformatf("v%0d_err", i), err, v.er);
    chk($sformatf("v%0d_ld_data", i), ld_data, v.ld);
    chk($sformatf("v%0d_req_resp", i), mif.mem_req, 1'b0);
    chk($sformatf("v%0d_stall_resp", i), stall, 1'b0);
    step();
    chk($sformatf("v%0d_done_idle", i), done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    // fields: we llen luns slen addr st rlo rhi nacc a0 be0 wd0 a1 be1 wd1 ld er
    tbl.push_back('{0, 3'b010, 0, 2'b00, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 1, 32'h100, 4'b1111, 32'h0, 32'h0, 4'b0, 32'h0, 32'hDEADBEEF, 0});
    tbl.push_back('{0, 3'b000, 0, 2'b00, 32'h103, 32'h0, 32'h80123456, 32'h0, 1, 32'h100, 4'b1000, 32'h0, 32'h0, 4'b0, 32'h0, 32'hFFFFFF80, 0});
    tbl.push_back('{0, 3'b100, 0, 2'b00, 32'h103, 32'h0, 32'h80123456, 32'h0, 1, 32'h100, 4'b1000, 32'h0, 32'h0, 4'b0, 32'h0, 32'h00000080, 0});
    tbl.push_back('{0, 3'b000, 1, 2'b00, 32'h103, 32'h0, 32'h80123456, 32'h0, 1, 32'h100, 4'b1000, 32'h0, 32'h0, 4'b0, 32'h0, 32'h00000080, 0});
    tbl.push_back('{1, 3'b000, 0, 2'b10, 32'h0FE, 32'h11223344, 32'h0, 32'h0, 2, 32'h0FC, 4'b1100, 32'h33440000, 32'h100, 4'b0011, 32'h00001122, 32'h0, 0});
    tbl.push_back('{0, 3'b001, 0, 2'b00, 32'h203, 32'h0, 32'hAB000000, 32'h000000CD, 2, 32'h200, 4'b1000, 32'h0, 32'h204, 4'b0001, 32'h0, 32'hFFFFCDAB, 0});
    tbl.push_back('{1, 3'b000, 0, 2'b11, 32'h100, 32'h12345678, 32'h0, 32'h0, 0, 32'h0, 4'b0, 32'h0, 32'h0, 4'b0, 32'h0, 32'h0, 1});
    tbl.push_back('{0, 3'b011, 0, 2'b00, 32'h100, 32'h0, 32'h0, 32'h0, 0, 32'h0, 4'b0, 32'h0, 32'h0, 4'b0, 32'h0, 32'h0, 1});
    tbl.push_back('{0, 3'b110, 0, 2'b00, 32'h100, 32'h0, 32'h0, 32'h0, 0, 32'h0, 4'b0, 32'h0, 32'h0, 4'b0, 32'h0, 32'h0, 1});
    tbl.push_back('{0, 3'b111, 0, 2'b00, 32'h100, 32'h0, 32'h0, 32'h0, 0, 32'h0, 4'b0, 32'h0, 32'h0, 4'b0, 32'h0, 32'h0, 1});
    tbl.push_back('{1, 3'b000, 0, 2'b00, 32'h101, 32'h000000A5, 32'h0, 32'h0, 1, 32'h100, 4'b0010, 32'h0000A500, 32'h0, 4'b0, 32'h0, 32'h0, 0});
    tbl.push_back('{1, 3'b000, 0, 2'b01, 32'h102, 32'h0000BEEF, 32'h0, 32'h0, 1, 32'h100, 4'b1100, 32'hBEEF0000, 32'h0, 4'b0, 32'h0, 32'h0, 0});
    tbl.push_back('{0, 3'b101, 0, 2'b00, 32'h102, 32'h0, 32'h80017777, 32'h0, 1, 32'h100, 4'b1100, 32'h0, 32'h0, 4'b0, 32'h0, 32'h00008001, 0});
    tbl.push_back('{0, 3'b001, 0, 2'b00, 32'h102, 32'h0, 32'h80017777, 32'h0, 1, 32'h100, 4'b1100, 32'h0, 32'h0, 4'b0, 32'h0, 32'hFFFF8001, 0});
    tbl.push_back('{0, 3'b001, 0, 2'b00, 32'h100, 32'h0, 32'h12347FFE, 32'h0, 1, 32'h100, 4'b0011, 32'h0, 32'h0, 4'b0, 32'h0, 32'h00007FFE, 0});
    tbl.push_back('{0, 3'b010, 0, 2'b00, 32'h101, 32'h0, 32'hCCBBAA99, 32'h000000DD, 2, 32'h100, 4'b1110, 32'h0, 32'h104, 4'b0001, 32'h0, 32'hDDCCBBAA, 0});
    tbl.push_back('{1, 3'b000, 0, 2'b10, 32'h103, 32'hAABBCCDD, 32'h0, 32'h0, 2, 32'h100, 4'b1000, 32'hDD000000, 32'h104, 4'b0111, 32'h00AABBCC, 32'h0, 0});

    rst = 1'b1; start = 1'b0; mem_wren = 1'b0; l_length = 3'b0; l_unsigned = 1'b0;
    s_length = 2'b0; addr = 32'h0; st_data = 32'h0;
    mif.mem_ack = 1'b0; mif.mem_rdata = 32'h0;
    step();
    step();
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_req", mif.mem_req, 1'b0);
    chk("rst_we", mif.mem_we, 1'b0);
    chk("rst_addr", mif.mem_addr, 32'h0);
    chk("rst_be", mif.mem_be, 4'h0);
    chk("rst_wdata", mif.mem_wdata, 32'h0);
    chk("rst_ld", ld_data, 32'h0);
    chk("rst_stall", stall, 1'b0);
    rst = 1'b0;
    mif.mem_ack = 1'b1;
    step();
    mif.mem_ack = 1'b0;
    chk("stray_ack_done", done, 1'b0);
    chk("stray_ack_req", mif.mem_req, 1'b0);

    for (int i = 0; i < tbl.size(); i++) run_vec(i, tbl[i]);

    // Wait states: ack held low three cycles
    mem_wren = 1'b0; l_length = 3'b010; l_unsigned = 1'b0; addr = 32'h100; start = 1'b1;
    step();
    start = 1'b0;
    addr = 32'h0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wait%0d_req", k), mif.mem_req, 1'b1);
      chk($sformatf("wait%0d_addr", k), mif.mem_addr, 32'h100);
      chk($sformatf("wait%0d_be", k), mif.mem_be, 4'b1111);
      chk($sformatf("wait%0d_stall", k), stall, 1'b1);
      chk($sformatf("wait%0d_done", k), done, 1'b0);
      if (k == 3) begin
        mif.mem_ack = 1'b1;
        mif.mem_rdata = 32'hCAFEF00D;
      end
      step();
    end
    mif.mem_ack = 1'b0;
    chk("wait_done", done, 1'b1);
    chk("wait_ld", ld_data, 32'hCAFEF00D);
    step();

    // Back-to-back: start held through RESP, next access begins in IDLE
    addr = 32'h100; start = 1'b1;
    step();
    addr = 32'h204;
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h11111111;
    step();
    mif.mem_ack = 1'b0;
    chk("b2b_done1", done, 1'b1);
    chk("b2b_ld1", ld_data, 32'h11111111);
    step();
    chk("b2b_idle_req", mif.mem_req, 1'b0);
    chk("b2b_idle_stall", stall, 1'b1);
    chk("b2b_idle_done", done, 1'b0);
    step();
    chk("b2b_req2", mif.mem_req, 1'b1);
    chk("b2b_addr2", mif.mem_addr, 32'h204);
    start = 1'b0;
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h22222222;
    step();
    mif.mem_ack = 1'b0;
    chk("b2b_done2", done, 1'b1);
    chk("b2b_ld2", ld_data, 32'h22222222);
    step();

    // Reset asserted in ACC0
    addr = 32'h300; start = 1'b1;
    step();
    start = 1'b0;
    chk("mid_req_before", mif.mem_req, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_req_async", mif.mem_req, 1'b0);
    chk("mid_addr_async", mif.mem_addr, 32'h0);
    chk("mid_stall", stall, 1'b0);
    chk("mid_done", done, 1'b0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("mid_after%0d_done", k), done, 1'b0);
      chk($sformatf("mid_after%0d_req", k), mif.mem_req, 1'b0);
    end

    run_vec(99, tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
